memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the Y86-64 pipeline: the consumer of the execute stage's `e_*` bundle. It owns the M pipeline register and a request/acknowledge data-memory port. It performs the load or store selected by `M_icode` and presents the `m_*` bundle to write-back and forwarding. A multi-cycle access FSM stalls the pipeline while memory is busy, and a timeout counter turns a hung access into an address error.

## Interface
Parameters:
- `MEM_BYTES`, 8192: data memory size in bytes; any address ≥ this is an address error.
- `TIMEOUT`, 16: maximum ACCESS cycles without `dmem_ack` before the access is aborted.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `e_stat`  in  3, `e_icode`  in  4, `e_Cnd`  in  1, `e_valE`  in  64, `e_valA`  in  64, `e_dstE`  in  4, `e_dstM`  in  4  execute-stage results.
- `M_bubble`  in  1  load a bubble into the M register instead of `e_*`.
- `M_icode`  out  4, `M_Cnd`  out  1, `M_valA`  out  64  raw M-register fields, for mispredict detection.
- `m_stat`  out  3, `m_icode`  out  4, `m_valE`  out  64, `m_valM`  out  64, `m_dstE`  out  4, `m_dstM`  out  4  results to write-back and forwarding.
- `m_stall`  out  1  M stage busy; upstream must hold E.
- `dmem_req`  out  1, `dmem_we`  out  1, `dmem_addr`  out  64, `dmem_wdata`  out  64  data-memory request.
- `dmem_ack`  in  1, `dmem_rdata`  in  64  data-memory response.

## Operation
- **M register load.** Loads on every rising edge where `m_stall`=0.
  - `M_bubble`=1: load a bubble (icode INOP=1, stat SAOK=1, dstE/dstM RNONE=15, Cnd=0, valE/valA=0).
  - Otherwise: load `e_*`.
- **Address select.** `e_valE` for RMMOVQ(4), MRMOVQ(5), CALL(8), PUSHQ(10). `M_valA` for POPQ(11) and RET(9).
- **Access type.** Reads: MRMOVQ, POPQ, RET. Writes: RMMOVQ, CALL, PUSHQ, with `dmem_wdata`=`M_valA`. All other icodes are non-memory.
- **Address error.** A memory op with `M_stat`=SAOK and `addr`+8 > `MEM_BYTES` issues no request and reports `m_stat`=SADR(2).
- **FSM states.**
  - IDLE: the M register holds a non-memory op, a bad-address op, or non-AOK stat. No request; `m_stall`=0.
  - ACCESS: `dmem_req`=1 and `m_stall`=1; the timeout counter increments each cycle.
    - On `dmem_ack`: capture `dmem_rdata` into `m_valM` (reads only) and go to DONE.
    - When the counter reaches `TIMEOUT`-1 without ack: set the error flag and go to DONE.
  - DONE: `m_stall`=0, results valid. The next edge reloads M and re-enters ACCESS or IDLE according to the new contents.
- **Entry to ACCESS.** Decided at the load edge from the incoming `e_*` values (valid-address memory op with SAOK stat).
- **Status.** `m_stat` = SADR when the bad-address check fires or the timeout error flag is set; otherwise `M_stat`.
- **Pass-through.** `m_icode`, `m_valE`, `m_dstE`, `m_dstM` come straight from the M register.
- **Non-AOK stat** (SADR, SINS, SHLT): the instruction never accesses memory, and the status passes through unchanged.

## Timing
- **Reset.** All M fields take bubble values. State IDLE, counter 0, `m_valM`=0. `dmem_req`, `dmem_we`, `m_stall` = 0, `dmem_addr`/`dmem_wdata`=0.
- **Reset mid-ACCESS.** `dmem_req` drops immediately (asynchronous). A late `dmem_ack` after reset is ignored.
- **Latency.** Non-memory op occupies M for 1 cycle. Memory op occupies M for (ACCESS cycles up to and including ack) + 1 DONE cycle, minimum 2.
- **Request stability.** `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_wdata` are held stable throughout ACCESS.
- **Ack outside ACCESS.** Ignored.
- **Simultaneous ack and timeout** in the same cycle: ack wins, no error.
- **`M_bubble` while `m_stall`=1:** ignored; the stall has priority and the M register holds.

## Structure
- Shared package `y86_pkg`:
  - icode constants IHALT…IPOPQ.
  - stat codes SAOK/SADR/SINS/SHLT.
  - RNONE.
  - Memory-stage FSM state enum.
- Sub-module `mem_access_fsm`: state register, timeout counter, and `dmem_*` handshake. The top level holds the M register, address/type select, and status merge.

## Test plan
- MRMOVQ with `e_valE`=0x100; memory acks 3 cycles after request with rdata=0xDEADBEEF → `m_stall` high for 3 cycles, then `m_valM`=0xDEADBEEF, `m_stat`=SAOK.
- PUSHQ with `e_valE`=0x1F8 and `e_valA`=0x55, zero-wait ack → one write with `dmem_we`=1, addr 0x1F8, wdata 0x55. M occupied exactly 2 cycles.
- RMMOVQ with `e_valE`=0x2000 and `MEM_BYTES`=8192 → no `dmem_req`, `m_stat`=SADR, `m_stall`=0.
- MRMOVQ that is never acked, `TIMEOUT`=16 → `dmem_req` high for 16 cycles, then `m_stat`=SADR and the stall releases.
- OPQ, then `M_bubble`=1, then `rst` asserted mid-ACCESS of a POPQ:
  - OPQ passes through in 1 cycle.
  - The bubble yields `m_icode`=1, dstE/dstM=15.
  - The reset drops `dmem_req` in the same cycle and returns all outputs to reset values.
- Ack arriving in the same cycle as the timeout terminal count → data captured, `m_stat`=SAOK.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, register ids,
// memory-stage FSM states and the M pipeline register layout.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_ACCESS,
    MS_DONE
  } mem_state_e;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic logic is_rd(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
  endfunction

  function automatic logic is_wr(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

  // Stack pops read through the old %rsp carried in valA.
  function automatic logic [63:0] sel_addr(
    input logic [3:0]  ic,
    input logic [63:0] val_e,
    input logic [63:0] val_a
  );
    return ((ic == IPOPQ) || (ic == IRET)) ? val_a : val_e;
  endfunction

  function automatic logic addr_bad(
    input logic [63:0] a,
    input logic [64:0] lim
  );
    return ({1'b0, a} + 65'd8) > lim;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Request/acknowledge data-memory port between the M stage
// and the data memory.
interface memory_stage_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE/ACCESS/DONE state, timeout
// counter, request drive and read-data capture.
module mem_access_fsm
  import y86_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           rd,
  input  logic           we,
  input  logic [63:0]    addr,
  input  logic [63:0]    wdata,
  memory_stage_if.master dmem,
  output logic           stall,
  output logic [63:0]    val_m,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  mem_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0]   val_m_n;
  logic          err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MS_IDLE;
      cnt   <= '0;
      val_m <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      val_m <= val_m_n;
      err   <= err_n;
    end
  end

  // Outside ACCESS every edge reloads M, so the next state follows
  // the incoming instruction.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    val_m_n = val_m;
    err_n   = err;
    unique case (state)
      MS_ACCESS: begin
        if (dmem.ack) begin
          state_n = MS_DONE;
          if (rd) val_m_n = dmem.rdata;
        end else if (cnt == LAST) begin
          state_n = MS_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = start ? MS_ACCESS : MS_IDLE;
        cnt_n   = '0;
        err_n   = 1'b0;
      end
    endcase
  end

  assign stall      = (state == MS_ACCESS);
  assign dmem.req   = stall;
  assign dmem.we    = stall & we;
  assign dmem.addr  = stall ? addr : '0;
  assign dmem.wdata = (stall && we) ? wdata : '0;

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, address/type select,
// bad-address check and status merge around the access FSM.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     e_stat,
  input  logic [3:0]     e_icode,
  input  logic           e_Cnd,
  input  logic [63:0]    e_valE,
  input  logic [63:0]    e_valA,
  input  logic [3:0]     e_dstE,
  input  logic [3:0]     e_dstM,
  input  logic           M_bubble,
  output logic [3:0]     M_icode,
  output logic           M_Cnd,
  output logic [63:0]    M_valA,
  output logic [2:0]     m_stat,
  output logic [3:0]     m_icode,
  output logic [63:0]    m_valE,
  output logic [63:0]    m_valM,
  output logic [3:0]     m_dstE,
  output logic [3:0]     m_dstM,
  output logic           m_stall,
  memory_stage_if.master dmem
);

  localparam logic [64:0] LIM = 65'(MEM_BYTES);

  m_reg_t      m_r;
  m_reg_t      e_in;
  logic        e_go;
  logic        m_mem;
  logic        m_bad;
  logic        m_rd;
  logic        m_wr;
  logic [63:0] m_addr;
  logic        err;

  assign e_in = '{
    stat:  e_stat,
    icode: e_icode,
    cnd:   e_Cnd,
    val_e: e_valE,
    val_a: e_valA,
    dst_e: e_dstE,
    dst_m: e_dstM
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r <= M_BUBBLE;
    end else if (!m_stall) begin
      m_r <= M_bubble ? M_BUBBLE : e_in;
    end
  end

  // ACCESS entry is judged on what is about to be loaded.
  assign e_go = !M_bubble
             && (is_rd(e_icode) || is_wr(e_icode))
             && (e_stat == SAOK)
             && !addr_bad(sel_addr(e_icode, e_valE, e_valA), LIM);

  assign m_rd   = is_rd(m_r.icode);
  assign m_wr   = is_wr(m_r.icode);
  assign m_mem  = m_rd | m_wr;
  assign m_addr = sel_addr(m_r.icode, m_r.val_e, m_r.val_a);
  assign m_bad  = m_mem && (m_r.stat == SAOK) && addr_bad(m_addr, LIM);

  mem_access_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (e_go),
    .rd    (m_rd),
    .we    (m_wr),
    .addr  (m_addr),
    .wdata (m_r.val_a),
    .dmem  (dmem),
    .stall (m_stall),
    .val_m (m_valM),
    .err   (err)
  );

  assign m_stat  = (m_bad || err) ? SADR : m_r.stat;
  assign M_icode = m_r.icode;
  assign M_Cnd   = m_r.cnd;
  assign M_valA  = m_r.val_a;
  assign m_icode = m_r.icode;
  assign m_valE  = m_r.val_e;
  assign m_dstE  = m_r.dst_e;
  assign m_dstM  = m_r.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage with a latency-programmable
// memory responder and a directed reset-during-access sequence.
module tb_memory_stage;
  import y86_pkg::*;

  localparam int MB = 8192;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        M_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        m_stall;

  memory_stage_if dmem ();

  memory_stage #(.MEM_BYTES(MB), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .e_stat   (e_stat),
    .e_icode  (e_icode),
    .e_Cnd    (e_Cnd),
    .e_valE   (e_valE),
    .e_valA   (e_valA),
    .e_dstE   (e_dstE),
    .e_dstM   (e_dstM),
    .M_bubble (M_bubble),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valA   (M_valA),
    .m_stat   (m_stat),
    .m_icode  (m_icode),
    .m_valE   (m_valE),
    .m_valM   (m_valM),
    .m_dstE   (m_dstE),
    .m_dstM   (m_dstM),
    .m_stall  (m_stall),
    .dmem     (dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    int          stalls;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
  } req_t;

  exp_t sb[$];
  req_t rq[$];
  int   tests = 0;
  int   fails = 0;

  logic [63:0] mm   [logic [63:0]];
  logic [63:0] rmem [logic [63:0]];
  logic [63:0] mval = 64'd0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [63:0] fill(input logic [63:0] a);
    return a ^ 64'h5A5A_0000_C3C3_1234;
  endfunction

  // Monitor: one pop per cycle in which M presents a finished result.
  bit   mon_on = 0;
  int   stalls = 0;
  exp_t x;
  always @(negedge clk) begin
    if (mon_on) begin
      if (m_stall) begin
        stalls++;
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got result icode %h expected none", m_icode);
      end else begin
        x = sb.pop_front();
        chk("m_stat", 64'(m_stat), 64'(x.stat));
        chk("m_icode", 64'(m_icode), 64'(x.icode));
        chk("m_valE", m_valE, x.val_e);
        chk("m_valM", m_valM, x.val_m);
        chk("m_dstE", 64'(m_dstE), 64'(x.dst_e));
        chk("m_dstM", 64'(m_dstM), 64'(x.dst_m));
        chk("M_icode", 64'(M_icode), 64'(x.icode));
        chk("M_Cnd", 64'(M_Cnd), 64'(x.cnd));
        chk("M_valA", M_valA, x.val_a);
        chk("stall_cycles", 64'(stalls), 64'(x.stalls));
        stalls = 0;
      end
    end
  end

  // Memory responder: acks after the programmed number of extra cycles.
  bit   resp_on = 1;
  logic force_ack = 1'b0;
  bit   ractive = 0;
  int   rcnt = 0;
  req_t cur;
  always @(negedge clk) begin
    if (!resp_on) begin
      dmem.ack   = force_ack;
      dmem.rdata = {$urandom, $urandom};
    end else if (dmem.req) begin
      if (!ractive) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem.addr);
          cur = '{we: 1'b0, addr: 64'd0, wdata: 64'd0, lat: 999};
        end else begin
          cur = rq.pop_front();
        end
        ractive = 1;
        rcnt = 0;
      end else begin
        rcnt++;
      end
      chk("req_we", 64'(dmem.we), 64'(cur.we));
      chk("req_addr", dmem.addr, cur.addr);
      if (cur.we) chk("req_wdata", dmem.wdata, cur.wdata);
      if (rcnt == cur.lat) begin
        dmem.ack = 1'b1;
        if (cur.we) rmem[cur.addr] = cur.wdata;
        dmem.rdata = rmem.exists(cur.addr) ? rmem[cur.addr] : fill(cur.addr);
      end else begin
        dmem.ack   = 1'b0;
        dmem.rdata = {$urandom, $urandom};
      end
    end else begin
      ractive = 0;
      dmem.ack   = 1'($urandom_range(0, 1));
      dmem.rdata = {$urandom, $urandom};
    end
  end

  // Drive one instruction into e_* and record what M must later show.
  task automatic issue(
    input logic        bub,
    input logic [2:0]  st,
    input logic [3:0]  ic,
    input logic        cnd,
    input logic [63:0] ve,
    input logic [63:0] va,
    input logic [3:0]  de,
    input logic [3:0]  dm,
    input int          lat
  );
    exp_t        e;
    logic [63:0] a;
    bit          rd;
    bit          mem;
    M_bubble = bub;
    e_stat   = st;
    e_icode  = ic;
    e_Cnd    = cnd;
    e_valE   = ve;
    e_valA   = va;
    e_dstE   = de;
    e_dstM   = dm;
    if (bub) begin
      e = '{stat: SAOK, icode: INOP, cnd: 1'b0, val_e: 64'd0, val_a: 64'd0,
            val_m: mval, dst_e: RNONE, dst_m: RNONE, stalls: 0};
    end else begin
      rd  = (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
      mem = rd || (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
      a   = (ic == IPOPQ || ic == IRET) ? va : ve;
      e = '{stat: st, icode: ic, cnd: cnd, val_e: ve, val_a: va,
            val_m: 64'd0, dst_e: de, dst_m: dm, stalls: 0};
      if (mem && st == SAOK) begin
        if (a > 64'(MB - 8)) begin
          e.stat = SADR;
        end else begin
          rq.push_back('{we: !rd, addr: a, wdata: va, lat: lat});
          if (lat >= TO) begin
            e.stalls = TO;
            e.stat = SADR;
          end else begin
            e.stalls = lat + 1;
            if (rd) mval = mm.exists(a) ? mm[a] : fill(a);
            else mm[a] = va;
          end
        end
      end
      e.val_m = mval;
    end
    sb.push_back(e);
  endtask

  task automatic wait_free();
    int w = 0;
    @(negedge clk);
    while (m_stall && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout: got m_stall 1 expected release within 100 cycles");
    end
  endtask

  function automatic logic [63:0] pick_addr();
    int r = $urandom_range(0, 9);
    if (r < 7) return 64'h100 + 64'(8 * $urandom_range(0, 15));
    if (r == 7) return 64'(MB - 8);
    if (r == 8) return 64'(MB - 7 + $urandom_range(0, 20));
    return 64'hFFFF_FFFF_FFFF_FFF8;
  endfunction

  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    if (r < 5) return r;
    if (r == 5) return 15;
    if (r == 6) return 16;
    if (r == 7) return 30;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ic;
    logic [63:0] va;
    rst = 1'b1;
    M_bubble = 1'b0;
    e_stat = SAOK;
    e_icode = INOP;
    e_Cnd = 1'b0;
    e_valE = 64'd0;
    e_valA = 64'd0;
    e_dstE = RNONE;
    e_dstM = RNONE;
    rmem[64'h100] = 64'hDEAD_BEEF;
    mm[64'h100] = 64'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(dmem.req), 64'd0);
    chk("rst_stall", 64'(m_stall), 64'd0);
    chk("rst_icode", 64'(m_icode), 64'(INOP));
    chk("rst_valM", m_valM, 64'd0);
    chk("rst_addr", dmem.addr, 64'd0);
    rst = 1'b0;
    sb.push_back('{stat: SAOK, icode: INOP, cnd: 1'b0, val_e: 64'd0, val_a: 64'd0,
                   val_m: 64'd0, dst_e: RNONE, dst_m: RNONE, stalls: 0});
    mon_on = 1;

    issue(0, SAOK, IMRMOVQ, 0, 64'h100, 64'd0, RNONE, 4'd3, 2);
    wait_free();
    issue(0, SAOK, IPUSHQ, 0, 64'h1F8, 64'h55, 4'd4, RNONE, 0);
    wait_free();
    issue(0, SAOK, IRMMOVQ, 0, 64'h2000, 64'd7, RNONE, RNONE, 0);
    wait_free();
    issue(0, SAOK, IMRMOVQ, 0, 64'h108, 64'd0, RNONE, 4'd1, 99);
    wait_free();
    issue(0, SAOK, IOPQ, 1, 64'd5, 64'd6, 4'd2, RNONE, 0);
    wait_free();
    issue(1, SAOK, IOPQ, 1, 64'd9, 64'd9, 4'd2, 4'd2, 0);
    wait_free();
    issue(0, SAOK, IMRMOVQ, 0, 64'h1F8, 64'd0, RNONE, 4'd5, 15);
    wait_free();
    issue(0, SHLT, IPOPQ, 0, 64'd0, 64'h100, 4'd4, 4'd0, 0);

    for (int i = 0; i < 250; i++) begin
      wait_free();
      if (i == 249) begin
        issue(1, SAOK, INOP, 0, 64'd0, 64'd0, RNONE, RNONE, 0);
      end else begin
        ic = 4'($urandom_range(0, 11));
        va = (ic == IPOPQ || ic == IRET) ? pick_addr() : {$urandom, $urandom};
        issue(1'($urandom_range(0, 9) == 0),
              ($urandom_range(0, 6) == 0) ? 3'($urandom_range(2, 4)) : SAOK,
              ic, 1'($urandom_range(0, 1)), pick_addr(), va,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), pick_lat());
      end
    end

    // Keep loading bubbles until every expectation has been retired.
    M_bubble = 1'b1;
    for (int w = 0; w < 300 && sb.size() != 0; w++) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    mon_on = 0;

    wait_free();
    M_bubble = 1'b0;
    e_stat = SAOK;
    e_icode = IPOPQ;
    e_valA = 64'h200;
    e_valE = 64'h208;
    e_dstE = 4'd4;
    e_dstM = 4'd0;
    rq.push_back('{we: 1'b0, addr: 64'h200, wdata: 64'd0, lat: 99});
    @(negedge clk);
    chk("popq_req", 64'(dmem.req), 64'd1);
    chk("popq_stall", 64'(m_stall), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 64'(dmem.req), 64'd0);
    chk("arst_stall", 64'(m_stall), 64'd0);
    chk("arst_icode", 64'(m_icode), 64'(INOP));
    chk("arst_dstE", 64'(m_dstE), 64'(RNONE));
    chk("arst_dstM", 64'(m_dstM), 64'(RNONE));
    chk("arst_valM", m_valM, 64'd0);
    chk("arst_stat", 64'(m_stat), 64'(SAOK));
    chk("arst_addr", dmem.addr, 64'd0);
    chk("arst_valA", M_valA, 64'd0);
    resp_on = 0;
    force_ack = 1'b1;
    M_bubble = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("late_ack_stall", 64'(m_stall), 64'd0);
      chk("late_ack_req", 64'(dmem.req), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
